wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Round-robin arbiter that shares the single-master Wishbone bus port between WB_NUM_MASTERS pipelined masters, e.g. CPU plus a DMA/video fetch engine.
- Grants one master at a time and holds the grant for its whole cycle, or longer while it asserts lock.
- Tracks outstanding transfers and enforces a stall on overflow.
- Aborts a hung slave with an error pulse after a timeout.

Parameters:
- WB_DATA_WIDTH, 8: data bus width.
- WB_ADDR_WIDTH, 16: address bus width.
- WB_NUM_MASTERS, 2: number of requesting masters (1..8).
- WB_MAX_OUTSTANDING, 15: maximum accepted-but-unacked strobes; 4-bit counter.
- WB_TIMEOUT, 255: cycles without ack while outstanding>0 before abort. 0 disables the timeout; 8-bit counter.

Ports:
- clk_i  in  1  single system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- m_cyc_i  in  N  per-master cycle.
- m_lock_i  in  N  per-master lock.
- m_stb_i  in  N  per-master strobe.
- m_we_i  in  N  per-master write enable.
- m_adr_i  in  N*A  per-master address, packed; master i at [i*A +: A].
- m_dat_i  in  N*D  per-master write data, packed.
- m_stall_o  out  N  per-master stall.
- m_ack_o  out  N  per-master ack.
- m_err_o  out  N  per-master timeout error, 1-cycle pulse.
- m_dat_o  out  N*D  read data, bus_dat_i replicated to every slice.
- bus_cyc_o, bus_lock_o, bus_stb_o, bus_we_o  out  1 each  to bus master port.
- bus_adr_o  out  A  to bus.
- bus_dat_o  out  D  to bus.
- bus_stall_i, bus_ack_i  in  1 each  from bus.
- bus_dat_i  in  D  from bus.
- grant_o  out  N  one-hot current grant; all zero when idle.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset (asynchronous, any time, including mid-transfer):
  - state=IDLE, grant_o=0, rr_ptr=0, outstanding=0, timer=0, m_err_o=0.
  - Bus outputs all 0, m_ack_o=0, m_stall_o all 1.
- FSM, two states: IDLE and GRANT.
- IDLE:
  - All bus_* outputs 0.
  - On a posedge with any m_cyc_i set: grant the first set bit searching from rr_ptr upward, wrapping modulo N.
  - state->GRANT and rr_ptr <= granted index + 1, modulo N.
  - Arbitration latency is 1 cycle from cyc to grant_o.
- GRANT, for granted index g:
  - bus_cyc_o, bus_lock_o, bus_we_o, bus_adr_o and bus_dat_o are combinationally muxed from master g.
  - bus_stb_o = m_stb_i[g] & ~full, where full = (outstanding==WB_MAX_OUTSTANDING).
  - m_stall_o[g] = bus_stall_i | full. Every non-granted master sees m_stall_o=1 and m_ack_o=0.
  - m_ack_o[g] = bus_ack_i.
- Outstanding counter:
  - +1 on accepted strobe (bus_stb_o & ~bus_stall_i).
  - -1 on bus_ack_i.
  - Unchanged when both occur in the same cycle.
  - Never underflows: a spurious ack at 0 is forwarded but the counter holds.
- Release, at a posedge in GRANT:
  - Condition: m_cyc_i[g]=0 and m_lock_i[g]=0.
  - state->IDLE, grant_o=0, outstanding=0.
  - A new grant needs one further edge, so there is a guaranteed 1-cycle bus-idle gap between owners.
  - While m_lock_i[g]=1 with cyc low, the grant is held; bus_cyc_o follows m_cyc_i[g] and stays low.
- Timeout:
  - timer increments each GRANT cycle with outstanding>0 and no ack; it clears on ack or when outstanding==0.
  - When timer reaches WB_TIMEOUT (nonzero): pulse m_err_o[g] for one cycle, then force state->IDLE, clearing grant, outstanding and timer. rr_ptr is already past g.
  - A late bus_ack_i while IDLE is dropped and not routed.
- Simultaneous events:
  - Release and a new request on the same edge: release wins; arbitration happens next edge.
  - Timeout and ack on the same cycle: the ack wins and the timer clears.
- N=1: the arbiter degenerates to a pass-through with a 1-cycle grant latency and the timeout still active.

Test Plan:
- Both masters raise cyc in the same cycle after reset → grant_o=01 one edge later. Master0 runs 3 single reads and drops cyc → 1 idle cycle, then grant_o=10.
- Master0 holds lock=1, drops cyc between two transfers while master1 requests → grant_o stays 01 until lock drops; master1 sees m_stall_o=1 throughout.
- Slave holds bus_stall_i=0 and never acks, master0 issues 15 strobes → 16th strobe stalled (bus_stb_o=0, m_stall_o[0]=1). After an ack, exactly one more strobe is accepted.
- WB_TIMEOUT=8, one strobe accepted, no ack → m_err_o[0] pulses exactly 8 cycles after acceptance, grant_o=0 next edge, and a late ack produces no m_ack_o.
- rst_ni pulled low mid-burst with outstanding=5 → all outputs reach reset values immediately without a clock edge. After release, first grant goes to master0.
- Three masters all requesting continuously with 1-transfer cycles → grant order 0,1,2,0,1,2 with an idle cycle between each.

Source files
------------

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: N pipelined masters share one bus master port,
// with an outstanding-strobe limit and a timeout that aborts a hung slave.
module wb_arbiter #(
  parameter int WB_DATA_WIDTH      = 8,
  parameter int WB_ADDR_WIDTH      = 16,
  parameter int WB_NUM_MASTERS     = 2,
  parameter int WB_MAX_OUTSTANDING = 15,
  parameter int WB_TIMEOUT         = 255
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [WB_NUM_MASTERS-1:0]              m_cyc_i,
  input  logic [WB_NUM_MASTERS-1:0]              m_lock_i,
  input  logic [WB_NUM_MASTERS-1:0]              m_stb_i,
  input  logic [WB_NUM_MASTERS-1:0]              m_we_i,
  input  logic [WB_NUM_MASTERS*WB_ADDR_WIDTH-1:0] m_adr_i,
  input  logic [WB_NUM_MASTERS*WB_DATA_WIDTH-1:0] m_dat_i,
  output logic [WB_NUM_MASTERS-1:0]              m_stall_o,
  output logic [WB_NUM_MASTERS-1:0]              m_ack_o,
  output logic [WB_NUM_MASTERS-1:0]              m_err_o,
  output logic [WB_NUM_MASTERS*WB_DATA_WIDTH-1:0] m_dat_o,
  output logic                                   bus_cyc_o,
  output logic                                   bus_lock_o,
  output logic                                   bus_stb_o,
  output logic                                   bus_we_o,
  output logic [WB_ADDR_WIDTH-1:0]               bus_adr_o,
  output logic [WB_DATA_WIDTH-1:0]               bus_dat_o,
  input  logic                                   bus_stall_i,
  input  logic                                   bus_ack_i,
  input  logic [WB_DATA_WIDTH-1:0]               bus_dat_i,
  output logic [WB_NUM_MASTERS-1:0]              grant_o
);

  localparam int N    = WB_NUM_MASTERS;
  localparam int A    = WB_ADDR_WIDTH;
  localparam int D    = WB_DATA_WIDTH;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic [IDXW-1:0] r_gidx;
  logic [IDXW-1:0] r_rr_ptr;
  logic [3:0]      r_outstanding;
  logic [7:0]      r_timer;
  logic            r_err;

  logic            w_in_grant;
  logic            w_full;
  logic            w_accept;
  logic            w_release;
  logic            w_timer_hit;
  logic            w_req_found;
  logic [IDXW-1:0] w_req_idx;
  logic [IDXW-1:0] w_rr_next;
  logic [N-1:0]    w_req_onehot;

  assign w_in_grant  = (r_state == GRANT);
  assign w_full      = (r_outstanding == 4'(WB_MAX_OUTSTANDING));
  assign w_accept    = bus_stb_o & ~bus_stall_i;
  assign w_release   = w_in_grant & ~m_cyc_i[r_gidx] & ~m_lock_i[r_gidx];
  assign w_timer_hit = (WB_TIMEOUT != 0) && (r_timer == 8'(WB_TIMEOUT - 1));
  assign grant_o     = r_grant;
  assign m_err_o     = r_err ? r_grant : '0;
  assign m_dat_o     = {N{bus_dat_i}};

  // Search downward so the candidate closest to r_rr_ptr is written last and wins.
  always_comb begin
    w_req_found  = 1'b0;
    w_req_idx    = '0;
    w_req_onehot = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (m_cyc_i[(int'(r_rr_ptr) + k) % N]) begin
        w_req_found = 1'b1;
        w_req_idx   = IDXW'((int'(r_rr_ptr) + k) % N);
      end
    end
    w_req_onehot[w_req_idx] = 1'b1;
    w_rr_next = (int'(w_req_idx) == N - 1) ? '0 : w_req_idx + 1'b1;
  end

  always_comb begin
    bus_cyc_o  = 1'b0;
    bus_lock_o = 1'b0;
    bus_stb_o  = 1'b0;
    bus_we_o   = 1'b0;
    bus_adr_o  = '0;
    bus_dat_o  = '0;
    m_stall_o  = '1;
    m_ack_o    = '0;
    if (w_in_grant) begin
      bus_cyc_o          = m_cyc_i[r_gidx];
      bus_lock_o         = m_lock_i[r_gidx];
      bus_stb_o          = m_stb_i[r_gidx] & ~w_full;
      bus_we_o           = m_we_i[r_gidx];
      bus_adr_o          = m_adr_i[int'(r_gidx)*A +: A];
      bus_dat_o          = m_dat_i[int'(r_gidx)*D +: D];
      m_stall_o[r_gidx]  = bus_stall_i | w_full;
      m_ack_o[r_gidx]    = bus_ack_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_gidx        <= '0;
      r_rr_ptr      <= '0;
      r_outstanding <= '0;
      r_timer       <= '0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_err         <= 1'b0;
          r_outstanding <= '0;
          r_timer       <= '0;
          if (w_req_found) begin
            r_state  <= GRANT;
            r_grant  <= w_req_onehot;
            r_gidx   <= w_req_idx;
            r_rr_ptr <= w_rr_next;
          end
        end
        GRANT: begin
          // The error pulse lasts one cycle; the abort follows on the next edge.
          if (w_release || r_err) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_outstanding <= '0;
            r_timer       <= '0;
            r_err         <= 1'b0;
          end else begin
            case ({w_accept, bus_ack_i})
              2'b10:   r_outstanding <= r_outstanding + 4'd1;
              2'b01:   if (r_outstanding != 4'd0) r_outstanding <= r_outstanding - 4'd1;
              default: r_outstanding <= r_outstanding;
            endcase
            if (bus_ack_i || r_outstanding == 4'd0 || WB_TIMEOUT == 0) begin
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + 8'd1;
              if (w_timer_hit) r_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
